serial_shift_pair: RTL and testbench



---
 rtl/serial_shift_pair_if.sv | 50 +++++
 rtl/serial_shift_pair.sv | 70 +++++++
 tb/tb_serial_shift_pair.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial_shift_pair_if.sv
// serial_shift_pair_if
//
// Purpose:
//   Bundles the datapath signals of serial_shift_pair so the staging block
//   and whatever sequences it (an FSM or a testbench) share one connection.
//   Clock and reset stay outside the interface as plain ports.
//
// Signals:
//   mode        1 = parallel load of the input register, 0 = shift right
//   ser_in      fill bit entering the input register MSB while shifting
//   par_in      parallel word loaded into the input register
//   ser_out     LSB of the input register (serial stream out)
//   in_state    full input register contents
//   out_ser_in  serial result bit captured by the output register each clock
//   out_par     full output register contents
//
// Modports:
//   master  drives the controls and the serial result bit, observes outputs
//   slave   the staging block itself
interface serial_shift_pair_if #(
    parameter int WIDTH = 8
);
    logic             mode;
    logic             ser_in;
    logic [WIDTH-1:0] par_in;
    logic             ser_out;
    logic [WIDTH-1:0] in_state;
    logic             out_ser_in;
    logic [WIDTH-1:0] out_par;

    modport master (
        output mode,
        output ser_in,
        output par_in,
        output out_ser_in,
        input  ser_out,
        input  in_state,
        input  out_par
    );

    modport slave (
        input  mode,
        input  ser_in,
        input  par_in,
        input  out_ser_in,
        output ser_out,
        output in_state,
        output out_par
    );
endinterface

// File: rtl/serial_shift_pair.sv
// serial_shift_pair
//
// Purpose:
//   Staging registers around a bit-serial arithmetic stage. The input half
//   turns a parallel word into an LSB-first bit stream; the output half
//   reassembles an LSB-first result stream into a parallel word. The two
//   halves are independent and share only clk and rst; the controlling FSM
//   sequences them purely by cycle count.
//
// Parameters:
//   WIDTH  word width of both registers (at least 2)
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset, clears both registers
//   bus  serial_shift_pair_if slave modport:
//          mode, ser_in, par_in  -> input register control and data
//          ser_out, in_state     <- input register LSB and contents
//          out_ser_in            -> result bit captured every clock
//          out_par               <- output register contents
module serial_shift_pair #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_shift_pair_if.slave   bus
);

    // A one-bit register cannot shift anything into its own MSB in a useful
    // way, and the slice [WIDTH-1:1] below would be malformed, so refuse it.
    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_shift_pair: WIDTH must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] in_reg;
    logic [WIDTH-1:0] out_reg;

    // Input register: reset beats load, load beats shift. While shifting,
    // ser_in enters at the MSB so after WIDTH shifts only fill bits remain;
    // par_in is ignored here and ser_in is ignored while loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg <= '0;
        end else if (bus.mode) begin
            in_reg <= bus.par_in;
        end else begin
            in_reg <= {bus.ser_in, in_reg[WIDTH-1:1]};
        end
    end

    // Output register: no enable, it captures out_ser_in on every edge.
    // Bits arriving LSB-first march down from the MSB, so after WIDTH edges
    // the first bit received sits in out_reg[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else begin
            out_reg <= {bus.out_ser_in, out_reg[WIDTH-1:1]};
        end
    end

    // ser_out is taken straight from state so a freshly loaded bit 0 is
    // visible in the cycle right after the load edge.
    assign bus.ser_out  = in_reg[0];
    assign bus.in_state = in_reg;
    assign bus.out_par  = out_reg;

endmodule

// File: tb/tb_serial_shift_pair.sv
// tb_serial_shift_pair
//
// Purpose:
//   Self-checking bench for serial_shift_pair. A stimulus process drives one
//   set of inputs per clock and pushes the expected post-edge outputs, taken
//   from an arithmetic reference model, into a scoreboard queue. A monitor
//   pops one entry after every rising edge and compares it to the DUT.
module tb_serial_shift_pair;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] in_state;
        logic         ser_out;
        logic [W-1:0] out_par;
    } exp_t;

    logic clk;
    logic rst;

    serial_shift_pair_if #(.WIDTH(W)) bus ();

    serial_shift_pair #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the input register as a number that is either
    // replaced or halved with the fill bit added at weight 2^(W-1); the
    // output register as the history of the last W result bits, oldest first.
    int unsigned model_in;
    bit          out_hist[$];

    function automatic logic [W-1:0] model_out_word();
        int unsigned v;
        v = 0;
        for (int i = 0; i < W; i++) begin
            if (out_hist[i]) v = v + (32'd1 << i);
        end
        return W'(v);
    endfunction

    // Compare one observed field with its expected value.
    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one clock's worth of inputs on the falling edge, advance the
    // model by one edge and queue what the DUT should show after the edge.
    // With loop set, the result bit is the DUT's own ser_out (loopback);
    // the model uses its own idea of that bit.
    task automatic applyStimulus(input bit r, input bit m, input bit si,
                                 input logic [W-1:0] pi, input bit osi,
                                 input bit loop);
        bit   osi_model;
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.mode   = m;
        bus.ser_in = si;
        bus.par_in = pi;
        bus.out_ser_in = loop ? bus.ser_out : osi;
        osi_model  = loop ? bit'(model_in & 1) : osi;

        if (r) begin
            model_in = 0;
            out_hist = {};
            for (int i = 0; i < W; i++) out_hist.push_back(1'b0);
        end else begin
            if (m) model_in = int'(pi);
            else   model_in = (model_in / 2) + (si ? (32'd1 << (W - 1)) : 0);
            out_hist.push_back(osi_model);
            void'(out_hist.pop_front());
        end

        e.in_state = W'(model_in);
        e.ser_out  = (model_in % 2) == 1;
        e.out_par  = model_out_word();
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("in_state", bus.in_state, e.in_state);
                checkOutput("ser_out", W'(bus.ser_out), W'(e.ser_out));
                checkOutput("out_par", bus.out_par, e.out_par);
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized run.
    initial begin
        int wait_cycles;
        rst = 1'b0;
        bus.mode = 1'b0;
        bus.ser_in = 1'b0;
        bus.par_in = '0;
        bus.out_ser_in = 1'b0;
        model_in = 0;
        for (int i = 0; i < W; i++) out_hist.push_back(1'b0);

        // Reset with arbitrary inputs.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);

        // Load 0xA5 then shift 7 with zero fill.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Load 0x00 then fill with ones for 8 shifts.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Assemble 0x3C on the output register, LSB first, while the input
        // register keeps reloading a changing word.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] word;
            word = 8'h3C;
            applyStimulus(1'b0, 1'b1, 1'b0, W'(i * 17), word[i], 1'b0);
        end

        // Loopback: load 0x96, shift 7, then one more edge completes it.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset beats load on the same edge.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);

        // Reset in the middle of shifting out 0xFF, then load 0x01.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

        // Randomized run with occasional resets and loopback stretches.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 3) == 0),
                          1'($urandom),
                          W'($urandom),
                          1'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

        // Let the monitor drain the scoreboard, bounded.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
